// File: rtl/decode_stage_pipe_pkg.sv
// Shared definitions for the decode stage: immediate/destination select codes,
// instruction field positions and a small tag-compare helper.
package decode_stage_pipe_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT5  = 2'b00,
    IMM_SEXT8  = 2'b01,
    IMM_ZEXT5  = 2'b10,
    IMM_SEXT11 = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    RDST_RS   = 2'b00,
    RDST_RD   = 2'b01,
    RDST_LINK = 2'b10,
    RDST_RT   = 2'b11
  } reg_dst_e;

  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 1 << REG_IDX_W;
  localparam int RS_LSB    = 8;
  localparam int RT_LSB    = 5;
  localparam int RD_LSB    = 2;
  localparam int IMM5_W    = 5;
  localparam int IMM8_W    = 8;
  localparam int IMM11_W   = 11;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  function automatic logic idx_hit(input logic en, input reg_idx_t a, input reg_idx_t b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/decode_stage_pipe_rf_bypass.sv
// 8-entry register file: two asynchronous read ports, one synchronous write port,
// optional write-through so a same-cycle WB write is visible on the read ports.
module decode_stage_pipe_rf_bypass
  import decode_stage_pipe_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  reg_idx_t                    waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [1:0][REG_IDX_W-1:0]   raddr,
  output logic [1:0][DATA_W-1:0]      rdata
);

  logic [DATA_W-1:0] mem_reg [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_reg[i] <= '0;
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    if (BYPASS_EN) begin : g_byp
      assign rdata[gi] = idx_hit(we, waddr, raddr[gi]) ? wdata : mem_reg[raddr[gi]];
    end else begin : g_nobyp
      assign rdata[gi] = mem_reg[raddr[gi]];
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Instruction-decode stage: operand read, immediate/destination select, load-use
// hazard detection and the ID/EX register with valid/ready handshake.
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PC_W      = 16,
  parameter int CTRL_W    = 24,
  parameter int LINK_REG  = 7,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  output logic              id_ready,
  input  logic              flush,
  input  logic [1:0]        ctrl_regDst,
  input  logic [1:0]        ctrl_immSel,
  input  logic              ctrl_uses_rs,
  input  logic              ctrl_uses_rt,
  input  logic              ctrl_regWrite,
  input  logic              ctrl_memRead,
  input  logic [CTRL_W-1:0] ctrl_bundle,
  input  logic              wb_regWrite,
  input  logic [2:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              idex_valid,
  output logic [PC_W-1:0]   idex_pc,
  output logic [DATA_W-1:0] idex_reg1,
  output logic [DATA_W-1:0] idex_reg2,
  output logic [DATA_W-1:0] idex_imm,
  output logic [2:0]        idex_write_reg,
  output logic              idex_regWrite,
  output logic              idex_memRead,
  output logic [CTRL_W-1:0] idex_ctrl
);

  reg_idx_t                 rs_sel, rt_sel, rd_sel;
  logic [1:0][DATA_W-1:0]   rf_rdata;
  logic [DATA_W-1:0]        imm_next;
  reg_idx_t                 dst_next;
  logic                     advance, hazard, hold_fwd1, hold_fwd2;
  logic                     unused_opcode;

  logic                     idex_valid_reg;
  logic [PC_W-1:0]          idex_pc_reg;
  logic [DATA_W-1:0]        idex_reg1_reg, idex_reg2_reg, idex_imm_reg;
  reg_idx_t                 idex_write_reg_reg, rs_tag_reg, rt_tag_reg;
  logic                     idex_regWrite_reg, idex_memRead_reg;
  logic [CTRL_W-1:0]        idex_ctrl_reg;

  assign rs_sel        = if_instr[RS_LSB +: REG_IDX_W];
  assign rt_sel        = if_instr[RT_LSB +: REG_IDX_W];
  assign rd_sel        = if_instr[RD_LSB +: REG_IDX_W];
  assign unused_opcode = ^if_instr[15:IMM11_W];

  decode_stage_pipe_rf_bypass #(
    .DATA_W    (DATA_W),
    .BYPASS_EN (BYPASS_EN)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_regWrite),
    .waddr (wb_write_reg),
    .wdata (wb_data),
    .raddr ({rt_sel, rs_sel}),
    .rdata (rf_rdata)
  );

  always_comb begin
    imm_next = '0;
    case (imm_sel_e'(ctrl_immSel))
      IMM_SEXT5:  imm_next = {{(DATA_W-IMM5_W){if_instr[IMM5_W-1]}}, if_instr[IMM5_W-1:0]};
      IMM_SEXT8:  imm_next = {{(DATA_W-IMM8_W){if_instr[IMM8_W-1]}}, if_instr[IMM8_W-1:0]};
      IMM_ZEXT5:  imm_next = {{(DATA_W-IMM5_W){1'b0}}, if_instr[IMM5_W-1:0]};
      IMM_SEXT11: imm_next = {{(DATA_W-IMM11_W){if_instr[IMM11_W-1]}}, if_instr[IMM11_W-1:0]};
      default:    imm_next = '0;
    endcase
  end

  always_comb begin
    dst_next = rs_sel;
    case (reg_dst_e'(ctrl_regDst))
      RDST_RS:   dst_next = rs_sel;
      RDST_RD:   dst_next = rd_sel;
      RDST_LINK: dst_next = REG_IDX_W'(LINK_REG);
      RDST_RT:   dst_next = rt_sel;
      default:   dst_next = rs_sel;
    endcase
  end

  // A load already in ID/EX cannot forward to the instruction behind it: bubble once.
  assign advance  = ~idex_valid_reg | ex_ready;
  assign hazard   = idex_valid_reg & idex_memRead_reg & idex_regWrite_reg &
                    (idx_hit(ctrl_uses_rs, rs_sel, idex_write_reg_reg) |
                     idx_hit(ctrl_uses_rt, rt_sel, idex_write_reg_reg));
  assign id_ready = flush | (advance & ~hazard);

  assign hold_fwd1 = BYPASS_EN && idex_valid_reg && idx_hit(wb_regWrite, wb_write_reg, rs_tag_reg);
  assign hold_fwd2 = BYPASS_EN && idex_valid_reg && idx_hit(wb_regWrite, wb_write_reg, rt_tag_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_valid_reg     <= 1'b0;
      idex_pc_reg        <= '0;
      idex_reg1_reg      <= '0;
      idex_reg2_reg      <= '0;
      idex_imm_reg       <= '0;
      idex_write_reg_reg <= '0;
      idex_regWrite_reg  <= 1'b0;
      idex_memRead_reg   <= 1'b0;
      idex_ctrl_reg      <= '0;
      rs_tag_reg         <= '0;
      rt_tag_reg         <= '0;
    end else if (flush) begin
      idex_valid_reg <= 1'b0;
    end else if (advance) begin
      if (hazard || !if_valid) begin
        idex_valid_reg <= 1'b0;
      end else begin
        idex_valid_reg     <= 1'b1;
        idex_pc_reg        <= if_pc;
        idex_reg1_reg      <= rf_rdata[0];
        idex_reg2_reg      <= rf_rdata[1];
        idex_imm_reg       <= imm_next;
        idex_write_reg_reg <= dst_next;
        idex_regWrite_reg  <= ctrl_regWrite;
        idex_memRead_reg   <= ctrl_memRead;
        idex_ctrl_reg      <= ctrl_bundle;
        rs_tag_reg         <= rs_sel;
        rt_tag_reg         <= rt_sel;
      end
    end else begin
      // Stalled in ID/EX: keep operands current with WB so EX never sees a stale value.
      if (hold_fwd1) idex_reg1_reg <= wb_data;
      if (hold_fwd2) idex_reg2_reg <= wb_data;
    end
  end

  assign idex_valid     = idex_valid_reg;
  assign idex_pc        = idex_pc_reg;
  assign idex_reg1      = idex_reg1_reg;
  assign idex_reg2      = idex_reg2_reg;
  assign idex_imm       = idex_imm_reg;
  assign idex_write_reg = idex_write_reg_reg;
  assign idex_regWrite  = idex_regWrite_reg;
  assign idex_memRead   = idex_memRead_reg;
  assign idex_ctrl      = idex_ctrl_reg;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus random traffic, checked by a
// scoreboard monitor against an architectural register-file model.
module tb_decode_stage_pipe;

  localparam int DATA_W   = 16;
  localparam int PC_W     = 16;
  localparam int CTRL_W   = 24;
  localparam int LINK_REG = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_valid = 1'b0;
  logic [15:0]       if_instr = '0;
  logic [PC_W-1:0]   if_pc = '0;
  logic              id_ready;
  logic              flush = 1'b0;
  logic [1:0]        ctrl_regDst = '0;
  logic [1:0]        ctrl_immSel = '0;
  logic              ctrl_uses_rs = 1'b0;
  logic              ctrl_uses_rt = 1'b0;
  logic              ctrl_regWrite = 1'b0;
  logic              ctrl_memRead = 1'b0;
  logic [CTRL_W-1:0] ctrl_bundle = '0;
  logic              wb_regWrite = 1'b0;
  logic [2:0]        wb_write_reg = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              ex_ready = 1'b1;
  logic              idex_valid;
  logic [PC_W-1:0]   idex_pc;
  logic [DATA_W-1:0] idex_reg1, idex_reg2, idex_imm;
  logic [2:0]        idex_write_reg;
  logic              idex_regWrite, idex_memRead;
  logic [CTRL_W-1:0] idex_ctrl;

  decode_stage_pipe #(
    .DATA_W(DATA_W), .PC_W(PC_W), .CTRL_W(CTRL_W), .LINK_REG(LINK_REG), .BYPASS_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ctrl_regDst(ctrl_regDst), .ctrl_immSel(ctrl_immSel),
    .ctrl_uses_rs(ctrl_uses_rs), .ctrl_uses_rt(ctrl_uses_rt), .ctrl_regWrite(ctrl_regWrite),
    .ctrl_memRead(ctrl_memRead), .ctrl_bundle(ctrl_bundle), .wb_regWrite(wb_regWrite),
    .wb_write_reg(wb_write_reg), .wb_data(wb_data), .ex_ready(ex_ready),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_reg1(idex_reg1), .idex_reg2(idex_reg2),
    .idex_imm(idex_imm), .idex_write_reg(idex_write_reg), .idex_regWrite(idex_regWrite),
    .idex_memRead(idex_memRead), .idex_ctrl(idex_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [15:0]       imm;
    logic [2:0]        dst, rs, rt;
    logic              rw, mr;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] rf_model [8];
  int                checks = 0;
  int                errors = 0;
  bit                mon_en = 1'b0;
  bit                exp_ready = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_imm(input logic [15:0] ins, input logic [1:0] sel);
    int v;
    case (sel)
      2'd0:    begin v = int'(ins[4:0]);  if (v >= 16)   v -= 32;   end
      2'd1:    begin v = int'(ins[7:0]);  if (v >= 128)  v -= 256;  end
      2'd2:    v = int'(ins[4:0]);
      default: begin v = int'(ins[10:0]); if (v >= 1024) v -= 2048; end
    endcase
    return 16'(v);
  endfunction

  function automatic exp_t mk_exp();
    exp_t e;
    e.pc   = if_pc;
    e.imm  = exp_imm(if_instr, ctrl_immSel);
    e.rs   = if_instr[10:8];
    e.rt   = if_instr[7:5];
    case (ctrl_regDst)
      2'd0:    e.dst = e.rs;
      2'd1:    e.dst = if_instr[4:2];
      2'd2:    e.dst = 3'(LINK_REG);
      default: e.dst = e.rt;
    endcase
    e.rw   = ctrl_regWrite;
    e.mr   = ctrl_memRead;
    e.ctrl = ctrl_bundle;
    return e;
  endfunction

  // One clock of the reference: predict id_ready for the current inputs, then
  // apply the edge to the in-flight queue and the architectural register file.
  task automatic step();
    bit occ, hz, adv, acc;
    exp_t e;
    occ = (sb.size() != 0);
    hz  = 1'b0;
    if (occ && sb[0].mr && sb[0].rw)
      hz = (ctrl_uses_rs && if_instr[10:8] == sb[0].dst) ||
           (ctrl_uses_rt && if_instr[7:5] == sb[0].dst);
    adv       = !occ || ex_ready;
    exp_ready = flush || (adv && !hz);
    acc       = !flush && adv && !hz && if_valid;
    e         = mk_exp();
    @(posedge clk);
    #1;
    if (flush) sb.delete();
    else if (acc) sb.push_back(e);
    if (wb_regWrite) rf_model[wb_write_reg] = wb_data;
  endtask

  task automatic set_instr(input logic [15:0] ins, input logic [1:0] dst, input logic [1:0] isel,
                           input bit urs, input bit urt, input bit rw, input bit mr);
    if_valid      = 1'b1;
    if_instr      = ins;
    if_pc         = 16'($urandom);
    ctrl_regDst   = dst;
    ctrl_immSel   = isel;
    ctrl_uses_rs  = urs;
    ctrl_uses_rt  = urt;
    ctrl_regWrite = rw;
    ctrl_memRead  = mr;
    ctrl_bundle   = 24'($urandom);
  endtask

  task automatic idle();
    if_valid    = 1'b0;
    flush       = 1'b0;
    wb_regWrite = 1'b0;
    ex_ready    = 1'b1;
  endtask

  task automatic randomize_inputs();
    if_valid      = ($urandom_range(0, 9) < 7);
    if_instr      = 16'($urandom);
    if_pc         = 16'($urandom);
    ctrl_regDst   = 2'($urandom_range(0, 3));
    ctrl_immSel   = 2'($urandom_range(0, 3));
    ctrl_uses_rs  = 1'($urandom_range(0, 1));
    ctrl_uses_rt  = 1'($urandom_range(0, 1));
    ctrl_regWrite = ($urandom_range(0, 3) != 0);
    ctrl_memRead  = ($urandom_range(0, 9) < 4);
    ctrl_bundle   = 24'($urandom);
  endtask

  // Scoreboard monitor: sampled on the falling edge, pops whenever EX takes ID/EX.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("idex_valid", 64'(idex_valid), 64'(sb.size() != 0));
      chk("id_ready", 64'(id_ready), 64'(exp_ready));
      if (idex_valid && ex_ready && !flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: got idex_valid=1 expected no transaction");
        end else begin
          mon_e = sb.pop_front();
          chk("reg1", 64'(idex_reg1), 64'(rf_model[mon_e.rs]));
          chk("reg2", 64'(idex_reg2), 64'(rf_model[mon_e.rt]));
          chk("fields", {idex_pc, idex_imm, idex_write_reg, idex_regWrite, idex_memRead},
                        {mon_e.pc, mon_e.imm, mon_e.dst, mon_e.rw, mon_e.mr});
          chk("ctrl", 64'(idex_ctrl), 64'(mon_e.ctrl));
          $display("txn pc=%h rs=%0d rt=%0d reg1=%h reg2=%h imm=%h dst=%0d",
                   idex_pc, mon_e.rs, mon_e.rt, idex_reg1, idex_reg2, idex_imm, idex_write_reg);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) rf_model[i] = '0;

    // Reset held with random traffic on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      randomize_inputs();
      flush        = 1'($urandom_range(0, 1));
      ex_ready     = 1'($urandom_range(0, 1));
      wb_regWrite  = 1'($urandom_range(0, 1));
      wb_write_reg = 3'($urandom_range(0, 7));
      wb_data      = 16'($urandom);
      #1;
      chk("rst_idex_valid", 64'(idex_valid), 64'(0));
      chk("rst_idex_reg1", 64'(idex_reg1), 64'(0));
    end
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    #1;
    chk("rst_id_ready", 64'(id_ready), 64'(1));
    mon_en    = 1'b1;
    exp_ready = 1'b1;

    // Same-cycle WB bypass into the rs read.
    set_instr(16'h0300, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    wb_regWrite = 1'b1; wb_write_reg = 3'd3; wb_data = 16'hBEEF;
    step();
    chk("bypass_reg1", 64'(idex_reg1), 64'(16'hBEEF));
    idle();

    // Immediate forms.
    set_instr(16'h07FF, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("imm_sext11", 64'(idex_imm), 64'(16'hFFFF));
    set_instr(16'h0010, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("imm_zext5", 64'(idex_imm), 64'(16'h0010));
    set_instr(16'h0010, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("imm_sext5", 64'(idex_imm), 64'(16'hFFF0));
    idle();
    step();

    // Load-use: LD writes R2, ADD reads rs=R2 -> exactly one bubble.
    set_instr(16'h0140, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    set_instr(16'h0270, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("loaduse_stall", 64'(id_ready), 64'(0));
    step();
    chk("loaduse_bubble", 64'(idex_valid), 64'(0));
    chk("loaduse_retry_ready", 64'(id_ready), 64'(1));
    step();
    chk("loaduse_add_loaded", 64'(idex_valid), 64'(1));
    chk("loaduse_add_dst", 64'(idex_write_reg), 64'(4));
    idle();
    step();
    // Same pair without uses_rs: no stall.
    set_instr(16'h0140, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    set_instr(16'h0270, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("nouse_ready", 64'(id_ready), 64'(1));
    step();
    idle();
    step();

    // Hold-forwarding: rt=R5 parked in ID/EX while WB writes R5.
    set_instr(16'h00A0, 2'd3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    ex_ready = 1'b0;
    step();
    if_valid = 1'b0;
    step();
    wb_regWrite = 1'b1; wb_write_reg = 3'd5; wb_data = 16'h0042;
    step();
    chk("holdfwd_reg2", 64'(idex_reg2), 64'(16'h0042));
    idle();
    step();

    // Flush while a load-use hazard is pending and EX is stalled.
    set_instr(16'h0140, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    ex_ready = 1'b0;
    step();
    set_instr(16'h0270, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    ex_ready = 1'b0;
    flush    = 1'b1;
    #1;
    chk("flush_id_ready", 64'(id_ready), 64'(1));
    step();
    chk("flush_idex_valid", 64'(idex_valid), 64'(0));
    idle();
    step();

    // Random traffic; a refused instruction is re-presented until taken.
    for (int c = 0; c < 3000; c++) begin
      if (!(if_valid && !exp_ready)) randomize_inputs();
      flush        = ($urandom_range(0, 19) == 0);
      ex_ready     = ($urandom_range(0, 9) < 7);
      wb_regWrite  = 1'($urandom_range(0, 1));
      wb_write_reg = 3'($urandom_range(0, 7));
      wb_data      = 16'($urandom);
      step();
    end
    idle();
    step();

    // Reset while an instruction is held in ID/EX.
    set_instr(16'h0123, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    ex_ready = 1'b0;
    step();
    mon_en = 1'b0;
    chk("midstall_loaded", 64'(idex_valid), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("midstall_rst_valid", 64'(idex_valid), 64'(0));
    chk("midstall_rst_reg1", 64'(idex_reg1), 64'(0));
    sb.delete();
    for (int i = 0; i < 8; i++) rf_model[i] = '0;
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    #1;
    chk("midstall_id_ready", 64'(id_ready), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
